// File: rtl/rot_pkg.sv
// Shared types and constants for the multi-step rotate unit.
package rot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Largest rotation the single-step datapath can apply in one clock.
    localparam int STEP_MAX = 3;

endpackage

// File: rtl/rot_step.sv
// Purpose: wrap-around rotate of a word by 0..3 positions, right or left.
// Latency: combinational, zero cycles.
// Backpressure: none; the output follows the inputs.
module rot_step
    import rot_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] word,
    input  logic [1:0]       shamt,
    input  logic             dir,
    output logic [WIDTH-1:0] rotated
);

    logic [WIDTH-1:0] rot_r;
    logic [WIDTH-1:0] rot_l;

    always_comb begin
        rot_r = word;
        case (shamt)
            2'd1:    rot_r = {word[0],   word[WIDTH-1:1]};
            2'd2:    rot_r = {word[1:0], word[WIDTH-1:2]};
            2'd3:    rot_r = {word[2:0], word[WIDTH-1:3]};
            default: rot_r = word;
        endcase
    end

    always_comb begin
        rot_l = word;
        case (shamt)
            2'd1:    rot_l = {word[WIDTH-2:0], word[WIDTH-1]};
            2'd2:    rot_l = {word[WIDTH-3:0], word[WIDTH-1:WIDTH-2]};
            2'd3:    rot_l = {word[WIDTH-4:0], word[WIDTH-1:WIDTH-3]};
            default: rot_l = word;
        endcase
    end

    assign rotated = (dir == DIR_LEFT) ? rot_l : rot_r;

endmodule

// File: rtl/rot_seq_unit.sv
// Purpose: rotate a word by 0..WIDTH-1 positions, applying at most 3 positions per clock.
// Latency: out_valid one cycle after accept, plus ceil(amt/3) cycles when amt != 0.
// Backpressure: result and out_data hold while out_ready is low; no new command is accepted until then.
module rot_seq_unit
    import rot_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam logic [AMT_W-1:0] STEP_MAX_W = AMT_W'(STEP_MAX);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] acc;
    logic [AMT_W-1:0] rem;
    logic             dir;

    logic [1:0]       step;
    logic [AMT_W-1:0] rem_next;
    logic [WIDTH-1:0] acc_rot;
    logic             load;
    logic             advance;

    // Largest step that does not overshoot the remaining amount.
    assign step     = (rem > STEP_MAX_W) ? 2'(STEP_MAX) : rem[1:0];
    assign rem_next = rem - AMT_W'(step);

    rot_step #(
        .WIDTH (WIDTH)
    ) u_rot_step (
        .word    (acc),
        .shamt   (step),
        .dir     (dir),
        .rotated (acc_rot)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = (in_amt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                advance = 1'b1;
                if (rem_next == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc     <= '0;
            rem     <= '0;
            dir     <= DIR_RIGHT;
        end else begin
            state_q <= state_d;
            if (load) begin
                acc <= in_data;
                rem <= in_amt;
                dir <= in_dir;
            end else if (advance) begin
                acc <= acc_rot;
                rem <= rem_next;
            end
        end
    end

    // in_ready is masked by reset so nothing is offered while the unit is being cleared.
    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE);
    assign out_data  = acc;

endmodule

// File: tb/tb_rot_seq_unit.sv
// Directed test of rot_seq_unit at WIDTH=8: reset, latency, rotation results, backpressure, reset abort.
module tb_rot_seq_unit;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_dir;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    rot_seq_unit #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command and returns in cycle C+1, just after the accept edge.
    task automatic send(input logic [7:0] d, input logic [2:0] a, input logic dr, input string tag);
        int waited;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_dir   = dr;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_ready) check_val({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'hFF;
        in_amt   = 3'd0;
        in_dir   = 1'b0;
    endtask

    // Counts cycles from C+1 until out_valid, then checks latency and data.
    task automatic expect_result(input logic [7:0] exp_d, input int exp_lat, input string tag);
        int k;
        k = 1;
        while (!out_valid && k < 30) begin
            tick();
            k++;
        end
        check_val({tag, "_latency"}, 32'(k), 32'(exp_lat));
        check_val({tag, "_data"}, 32'(out_data), 32'(exp_d));
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val({tag, "_valid_after_take"}, 32'(out_valid), 32'd0);
        check_val({tag, "_ready_after_take"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic seen_valid;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_dir    = 1'b0;
        out_ready = 1'b0;

        repeat (2) tick();
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_data", 32'(out_data), 32'h00);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        tick();
        check_val("post_rst_in_ready", 32'(in_ready), 32'd1);

        send(8'h3C, 3'd0, 1'b0, "zero");
        expect_result(8'h3C, 1, "zero");
        drain("zero");

        send(8'hB4, 3'd1, 1'b0, "r1");
        expect_result(8'h5A, 2, "r1");
        drain("r1");

        send(8'h81, 3'd5, 1'b1, "l5");
        expect_result(8'h30, 3, "l5");
        drain("l5");

        send(8'h01, 3'd7, 1'b0, "r7");
        expect_result(8'h02, 4, "r7");
        drain("r7");

        send(8'hA5, 3'd3, 1'b1, "l3");
        expect_result(8'h2D, 2, "l3");
        drain("l3");

        send(8'h96, 3'd4, 1'b0, "r4");
        expect_result(8'h69, 3, "r4");
        drain("r4");

        // Backpressure with a second command waiting.
        send(8'hC3, 3'd2, 1'b1, "bp");
        expect_result(8'h0F, 2, "bp");
        in_valid = 1'b1;
        in_data  = 8'h11;
        in_amt   = 3'd1;
        in_dir   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("bp_hold_valid", 32'(out_valid), 32'd1);
            check_val("bp_hold_data", 32'(out_data), 32'h0F);
            check_val("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("bp_taken_valid", 32'(out_valid), 32'd0);
        check_val("bp_second_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'hFF;
        in_amt   = 3'd6;
        in_dir   = 1'b1;
        expect_result(8'h88, 2, "bp2");
        drain("bp2");

        // Reset during RUN must discard the in-flight result.
        send(8'h01, 3'd7, 1'b0, "abort");
        reset = 1'b1;
        tick();
        check_val("abort_out_valid", 32'(out_valid), 32'd0);
        check_val("abort_out_data", 32'(out_data), 32'h00);
        check_val("abort_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        tick();
        check_val("abort_in_ready_after", 32'(in_ready), 32'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        check_val("abort_no_stale_valid", 32'(seen_valid), 32'd0);

        send(8'h3C, 3'd0, 1'b1, "post_abort");
        expect_result(8'h3C, 1, "post_abort");
        drain("post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
